// File: rtl/dbus_pkg.sv
// Shared types and address-decode helper for the data bus bridge.
package dbus_pkg;

    localparam int unsigned DBUS_REGION_MSB = 31;
    localparam int unsigned DBUS_REGION_LSB = 28;
    localparam int unsigned REGION_W        = DBUS_REGION_MSB - DBUS_REGION_LSB + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dbus_state_t;

    typedef struct packed {
        logic [REGION_W-1:0] idx;
        logic                mapped;
    } dbus_decode_t;

    function automatic dbus_decode_t dbus_decode(input logic [31:0] addr,
                                                 input int unsigned num_slaves);
        dbus_decode_t d;
        d.idx    = addr[DBUS_REGION_MSB:DBUS_REGION_LSB];
        d.mapped = (32'(d.idx) < num_slaves);
        return d;
    endfunction

endpackage

// File: rtl/dbus_timeout_timer.sv
// Clearable up-counter that flags expiry on the LIMIT-th enabled cycle.
module dbus_timeout_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    // r_count holds the number of enabled cycles already spent
    assign o_expired = i_en && (r_count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/data_bus_bridge.sv
// Single-outstanding bridge from the core data port to NUM_SLAVES regions.
// Optional ACCESS timeout enabled by defining DBUS_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for data_req_i, grant is combinational
// ACCESS | slave selected, waiting for its ready (or timeout)
// RESP   | one-cycle rvalid with registered rdata/err
module data_bus_bridge
    import dbus_pkg::*;
#(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     data_req_i,
    output logic                     data_gnt_o,
    output logic                     data_rvalid_o,
    input  logic                     data_we_i,
    input  logic [3:0]               data_be_i,
    input  logic [31:0]              data_addr_i,
    input  logic [31:0]              data_wdata_i,
    output logic [31:0]              data_rdata_o,
    output logic                     data_err_o,
    output logic [NUM_SLAVES-1:0]    s_sel_o,
    output logic                     s_we_o,
    output logic [3:0]               s_be_o,
    output logic [31:0]              s_addr_o,
    output logic [31:0]              s_wdata_o,
    input  logic [NUM_SLAVES-1:0]    s_ready_i,
    input  logic [NUM_SLAVES*32-1:0] s_rdata_i,
    input  logic [NUM_SLAVES-1:0]    s_err_i
);

    if (NUM_SLAVES < 1 || NUM_SLAVES > (1 << REGION_W)) begin : g_bad_num_slaves
        $error("NUM_SLAVES must be between 1 and the number of address regions");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    dbus_state_t         r_state, w_state_nxt;
    logic                r_we;
    logic [3:0]          r_be;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [REGION_W-1:0] r_idx;
    logic [31:0]         r_rdata, w_rdata_nxt;
    logic                r_err, w_err_nxt;

    dbus_decode_t          w_dec;
    logic                  w_accept;
    logic                  w_in_access;
    logic                  w_timeout;
    logic [NUM_SLAVES-1:0] w_onehot;
    logic                  w_slave_ready;
    logic                  w_slave_err;
    logic [31:0]           w_slave_rdata;

    assign w_dec       = dbus_decode(data_addr_i, NUM_SLAVES);
    assign w_in_access = (r_state == ACCESS);
    // rst gates the grant so a request seen during reset is never acknowledged
    assign w_accept    = (r_state == IDLE) && data_req_i && rst;

    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_onehot
        assign w_onehot[gi] = (r_idx == REGION_W'(gi));
    end

    assign w_slave_ready = |(s_ready_i & w_onehot);
    assign w_slave_err   = |(s_err_i & w_onehot);

    always_comb begin
        w_slave_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_onehot[i]) begin
                w_slave_rdata = s_rdata_i[i*32 +: 32];
            end
        end
    end

`ifdef DBUS_TIMEOUT_EN
    dbus_timeout_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout_timer (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_clear   (w_accept),
        .i_en      (w_in_access),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_rdata_nxt = r_rdata;
        w_err_nxt   = r_err;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_dec.mapped) begin
                        w_state_nxt = ACCESS;
                    end else begin
                        w_state_nxt = RESP;
                        w_rdata_nxt = '0;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // ready beats a coincident timeout
                if (w_slave_ready) begin
                    w_state_nxt = RESP;
                    w_err_nxt   = w_slave_err;
                    w_rdata_nxt = (r_we || w_slave_err) ? 32'd0 : w_slave_rdata;
                end else if (w_timeout) begin
                    w_state_nxt = RESP;
                    w_rdata_nxt = '0;
                    w_err_nxt   = 1'b1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_idx   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rdata <= w_rdata_nxt;
            r_err   <= w_err_nxt;
            if (w_accept) begin
                r_we    <= data_we_i;
                r_be    <= data_be_i;
                r_addr  <= data_addr_i;
                r_wdata <= data_wdata_i;
                r_idx   <= w_dec.idx;
            end
        end
    end

    assign data_gnt_o    = w_accept;
    assign data_rvalid_o = (r_state == RESP);
    assign data_rdata_o  = data_rvalid_o ? r_rdata : 32'd0;
    assign data_err_o    = data_rvalid_o && r_err;

    assign s_sel_o   = w_in_access ? w_onehot : '0;
    assign s_we_o    = w_in_access && r_we;
    assign s_be_o    = w_in_access ? r_be : 4'd0;
    assign s_addr_o  = w_in_access ? r_addr : 32'd0;
    assign s_wdata_o = w_in_access ? r_wdata : 32'd0;

endmodule
